// File: rtl/l15_pkg.sv
// rtl/l15_pkg.sv - request/response encodings, FSM state type and decode helpers for l15_responder
// Purpose: shared constants for the simplified L1.5 request/response interface,
//          the responder FSM state enum and small request-decode functions.
// Ports:   none (package).
package l15_pkg;

  localparam logic [5:0] LOAD_RQ  = 6'b000000;
  localparam logic [5:0] STORE_RQ = 6'b000001;

  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK   = 4'b0100;
  localparam logic [3:0] ERR_RET  = 4'b1100;

  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } l15_resp_state_t;

  // Unknown opcode, unknown size or a misaligned half/word access.
  function automatic logic l15_req_error(input logic [5:0] rqtype,
                                         input logic [2:0] size,
                                         input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    if (rqtype != LOAD_RQ && rqtype != STORE_RQ) err = 1'b1;
    case (size)
      SIZE_BYTE: ;
      SIZE_HALF: if (addr_lo[0]) err = 1'b1;
      SIZE_WORD: if (addr_lo != 2'b00) err = 1'b1;
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] l15_byte_en(input logic [2:0] size,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data arrives right-justified; copy it onto every lane so the
  // byte enables alone pick the destination.
  function automatic logic [31:0] l15_replicate(input logic [2:0]  size,
                                                input logic [31:0] data);
    logic [31:0] w;
    case (size)
      SIZE_BYTE: w = {4{data[7:0]}};
      SIZE_HALF: w = {2{data[15:0]}};
      default:   w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/l15_responder_if.sv
// rtl/l15_responder_if.sv - core<->L1.5 request/response signal bundle
// Purpose: groups the core_l15_* request and l15_core_* response signals.
// Modports:
//   master - requester (core side): drives core_l15_*, observes l15_core_*
//   slave  - responder (memory side): observes core_l15_*, drives l15_core_*
interface l15_responder_if;
  logic        core_l15_val;
  logic [5:0]  core_l15_rqtype;
  logic [2:0]  core_l15_size;
  logic [31:0] core_l15_address;
  logic [31:0] core_l15_data;

  logic        l15_core_header_ack;
  logic        l15_core_ack;
  logic        l15_core_val;
  logic [3:0]  l15_core_returntype;
  logic [31:0] l15_core_data_0;
  logic [31:0] l15_core_data_1;

  modport master (
    output core_l15_val, core_l15_rqtype, core_l15_size, core_l15_address, core_l15_data,
    input  l15_core_header_ack, l15_core_ack, l15_core_val, l15_core_returntype,
           l15_core_data_0, l15_core_data_1
  );

  modport slave (
    input  core_l15_val, core_l15_rqtype, core_l15_size, core_l15_address, core_l15_data,
    output l15_core_header_ack, l15_core_ack, l15_core_val, l15_core_returntype,
           l15_core_data_0, l15_core_data_1
  );
endinterface

// File: rtl/l15_resp_mem.sv
// rtl/l15_resp_mem.sv - single-port DEPTH x 32 RAM with byte-enable write and registered read
// Purpose: backing store for l15_responder. Contents are never reset.
// Ports:
//   clk     - clock
//   en_i    - access enable; read data registers only on enabled cycles
//   we_i    - per-byte write enables (lane 0 = bits [7:0])
//   addr_i  - word index
//   wdata_i - write data
//   rdata_o - registered read data (old contents on a same-cycle write)
module l15_resp_mem #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en_i,
  input  logic [3:0]               we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/l15_responder.sv
// rtl/l15_responder.sv - L1.5 stand-in: one request at a time, fixed latency, internal RAM
// Purpose: accepts a load/store request, pulses header_ack, waits LATENCY
//          cycles, then pulses a response carrying LOAD_RET/ST_ACK/ERR_RET.
// Ports:
//   clk - clock
//   rst - asynchronous active-high reset (memory contents survive it)
//   bus - l15_responder_if.slave: core_l15_* request in, l15_core_* response out
// Parameters: DEPTH (words, power of two), LATENCY (0..255 extra wait cycles)
module l15_responder
  import l15_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  l15_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  l15_resp_state_t state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [5:0]      rqtype_q, rqtype_d;
  logic [2:0]      size_q, size_d;
  logic [AW+1:0]   addr_q, addr_d;   // only the bits that select a byte in memory
  logic [31:0]     data_q, data_d;

  logic            req_err;
  logic            is_store;
  logic            mem_en;
  logic [3:0]      mem_we;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;

  assign req_err   = l15_req_error(rqtype_q, size_q, addr_q[1:0]);
  assign is_store  = (rqtype_q == STORE_RQ);
  assign mem_wdata = l15_replicate(size_q, data_q);

  l15_resp_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .en_i    (mem_en),
    .we_i    (mem_we),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      rqtype_q <= 6'd0;
      size_q   <= 3'd0;
      addr_q   <= '0;
      data_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rqtype_q <= rqtype_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rqtype_d = rqtype_q;
    size_d   = size_q;
    addr_d   = addr_q;
    data_d   = data_q;
    mem_en   = 1'b0;
    mem_we   = 4'b0000;

    bus.l15_core_header_ack = 1'b0;
    bus.l15_core_ack        = 1'b0;
    bus.l15_core_val        = 1'b0;
    bus.l15_core_returntype = 4'b0000;
    bus.l15_core_data_0     = 32'd0;
    bus.l15_core_data_1     = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (bus.core_l15_val) begin
          rqtype_d = bus.core_l15_rqtype;
          size_d   = bus.core_l15_size;
          addr_d   = bus.core_l15_address[AW+1:0];
          data_d   = bus.core_l15_data;
          state_d  = S_ACK;
        end
      end

      S_ACK: begin
        bus.l15_core_header_ack = 1'b1;
        bus.l15_core_ack        = 1'b1;
        cnt_d  = 8'(LATENCY);
        // Read every request here; the registered word holds until RESP
        // because the RAM is not enabled again before then.
        mem_en = 1'b1;
        if (is_store && !req_err) mem_we = l15_byte_en(size_q, addr_q[1:0]);
        state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
      end

      S_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = S_RESP;
      end

      S_RESP: begin
        bus.l15_core_val = 1'b1;
        if (req_err) begin
          bus.l15_core_returntype = ERR_RET;
        end else if (is_store) begin
          bus.l15_core_returntype = ST_ACK;
        end else begin
          bus.l15_core_returntype = LOAD_RET;
          bus.l15_core_data_0     = mem_rdata;
        end
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_l15_responder.sv
// tb/tb_l15_responder.sv - self-checking bench for l15_responder (LATENCY 2 and 0 instances)
module tb_l15_responder;
  import l15_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // shared request drive; sel picks which instance sees val
  logic        val;
  logic [5:0]  rq;
  logic [2:0]  sz;
  logic [31:0] addr;
  logic [31:0] data;
  int          sel;

  l15_responder_if ifa ();
  l15_responder_if ifb ();

  assign ifa.core_l15_val     = val && (sel == 0);
  assign ifa.core_l15_rqtype  = rq;
  assign ifa.core_l15_size    = sz;
  assign ifa.core_l15_address = addr;
  assign ifa.core_l15_data    = data;
  assign ifb.core_l15_val     = val && (sel == 1);
  assign ifb.core_l15_rqtype  = rq;
  assign ifb.core_l15_size    = sz;
  assign ifb.core_l15_address = addr;
  assign ifb.core_l15_data    = data;

  l15_responder #(.DEPTH(1024), .LATENCY(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  l15_responder #(.DEPTH(1024), .LATENCY(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  logic        o_hack, o_ack, o_val;
  logic [3:0]  o_rt;
  logic [31:0] o_d0, o_d1;
  always_comb begin
    if (sel == 0) begin
      o_hack = ifa.l15_core_header_ack; o_ack = ifa.l15_core_ack; o_val = ifa.l15_core_val;
      o_rt = ifa.l15_core_returntype; o_d0 = ifa.l15_core_data_0; o_d1 = ifa.l15_core_data_1;
    end else begin
      o_hack = ifb.l15_core_header_ack; o_ack = ifb.l15_core_ack; o_val = ifb.l15_core_val;
      o_rt = ifb.l15_core_returntype; o_d0 = ifb.l15_core_data_0; o_d1 = ifb.l15_core_data_1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mb  [2][4096];   // byte image of each instance's memory (4*DEPTH bytes)
  bit         mbv [2][4096];   // byte has been written
  int         lat [2];
  int         free_c [2];      // earliest cycle each instance may sample a request
  bit          exp_hack [int];
  logic [35:0] exp_resp [int]; // {returntype, data_0}
  bit          exp_dc   [int]; // load of never-written bytes: data not checked

  function automatic void predict(input int t, input logic [5:0] r, input logic [2:0] s,
                                  input logic [31:0] a, input logic [31:0] d);
    int st, base, nb;
    bit ok, known;
    logic [3:0]  rt;
    logic [31:0] w;
    st = (t > free_c[sel]) ? t : free_c[sel];
    ok = (r == 6'd0 || r == 6'd1) &&
         (s == 3'd0 || (s == 3'd1 && a[0] == 1'b0) || (s == 3'd2 && a[1:0] == 2'b00));
    base  = int'(a[11:0]);
    rt    = 4'b1100;
    w     = 32'd0;
    known = 1'b1;
    if (ok && r == 6'd1) begin
      nb = 1 << int'(s);
      for (int i = 0; i < nb; i++) begin
        mb[sel][base + i]  = d[8*i +: 8];
        mbv[sel][base + i] = 1'b1;
      end
      rt = 4'b0100;
    end else if (ok) begin
      base = base - (base % 4);
      for (int i = 0; i < 4; i++) begin
        w[8*i +: 8] = mb[sel][base + i];
        if (!mbv[sel][base + i]) known = 1'b0;
      end
      rt = 4'b0000;
    end
    exp_hack[st + 1]            = 1'b1;
    exp_resp[st + 2 + lat[sel]] = {rt, w};
    exp_dc[st + 2 + lat[sel]]   = !known;
    free_c[sel]                 = st + 3 + lat[sel];
  endfunction

  // ---------------- compare process ----------------
  logic [3:0]  last_rt;
  logic [31:0] last_d;
  int          last_cyc;
  int          resp_cycs[$];

  always @(negedge clk) begin
    bit eh, ev;
    eh = exp_hack.exists(cyc) != 0;
    ev = exp_resp.exists(cyc) != 0;
    chk("header_ack", 64'(o_hack), 64'(eh));
    chk("ack", 64'(o_ack), 64'(eh));
    chk("resp_val", 64'(o_val), 64'(ev));
    chk("data_1", 64'(o_d1), 64'd0);
    if (o_val && ev) begin
      chk("returntype", 64'(o_rt), 64'(exp_resp[cyc][35:32]));
      if (!exp_dc[cyc]) chk("data_0", 64'(o_d0), 64'(exp_resp[cyc][31:0]));
    end
    if (o_val) begin
      last_rt  <= o_rt;
      last_d   <= o_d0;
      last_cyc <= cyc;
      resp_cycs.push_back(cyc);
    end
  end

  // ---------------- driver ----------------
  int ack_cyc;

  // Called at a falling edge. gap==0 leaves val high so the next call
  // overlaps with the current transaction.
  task automatic do_req(input logic [5:0] r, input logic [2:0] s, input logic [31:0] a,
                        input logic [31:0] d, input int gap);
    int n;
    rq = r; sz = s; addr = a; data = d; val = 1'b1;
    predict(cyc, r, s, a, d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_hack && n < 20);
    ack_cyc = cyc;
    if (!o_hack) chk("header_ack_timeout", 64'(o_hack), 64'd1);
    if (gap > 0) begin
      val = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic drop_future();
    int ks[$];
    foreach (exp_resp[k]) if (k > cyc) ks.push_back(k);
    foreach (ks[i]) exp_resp.delete(ks[i]);
    ks.delete();
    foreach (exp_hack[k]) if (k > cyc) ks.push_back(k);
    foreach (ks[i]) exp_hack.delete(ks[i]);
  endtask

  task automatic random_phase(input int nreq);
    logic [5:0]  r;
    logic [2:0]  s;
    int          pick;
    for (int i = 0; i < 32; i++)
      do_req(STORE_RQ, SIZE_WORD, ($urandom & 32'hFFFFF000) | 32'(4 * i), $urandom,
             $urandom_range(0, 2));
    for (int i = 0; i < nreq; i++) begin
      r    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 1));
      pick = $urandom_range(0, 4);
      s    = (pick == 4) ? 3'($urandom_range(3, 7)) : 3'(pick % 3);
      do_req(r, s, $urandom & 32'hFFFFF07F, $urandom, $urandom_range(0, 3));
    end
    val = 1'b0;
    repeat (lat[sel] + 4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst = 1'b1;
    val = 1'b0; rq = '0; sz = '0; addr = '0; data = '0; sel = 0;
    lat[0] = 2; lat[1] = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_a", {26'd0, ifa.l15_core_header_ack, ifa.l15_core_ack, ifa.l15_core_val,
        ifa.l15_core_returntype, ifa.l15_core_data_0}, 64'd0);
    chk("reset_outputs_b", {26'd0, ifb.l15_core_header_ack, ifb.l15_core_ack, ifb.l15_core_val,
        ifb.l15_core_returntype, ifb.l15_core_data_0}, 64'd0);
    rst = 1'b0;
    free_c[0] = cyc + 1; free_c[1] = cyc + 1;
    @(negedge clk);

    // word store/load, LATENCY=2
    t0 = cyc;
    do_req(STORE_RQ, SIZE_WORD, 32'h40, 32'hDEADBEEF, 4);
    chk("st_hack_cycle", 64'(ack_cyc - t0), 64'd1);
    chk("st_resp_cycle", 64'(last_cyc - t0), 64'd4);
    chk("st_rtype", 64'(last_rt), 64'h4);
    do_req(LOAD_RQ, SIZE_WORD, 32'h40, 32'h0, 4);
    chk("ld_rtype", 64'(last_rt), 64'h0);
    chk("ld_data_40", 64'(last_d), 64'hDEADBEEF);

    // sub-word stores
    do_req(STORE_RQ, SIZE_WORD, 32'h80, 32'h0, 4);
    do_req(STORE_RQ, SIZE_BYTE, 32'h82, 32'hFFFFFFAA, 4);
    do_req(LOAD_RQ, SIZE_WORD, 32'h80, 32'h0, 4);
    chk("byte_store", 64'(last_d), 64'h00AA0000);
    do_req(STORE_RQ, SIZE_HALF, 32'h80, 32'hFFFF1234, 4);
    do_req(LOAD_RQ, SIZE_WORD, 32'h80, 32'h0, 4);
    chk("half_store", 64'(last_d), 64'h00AA1234);

    // errors
    do_req(STORE_RQ, SIZE_HALF, 32'h81, 32'hFFFFFFFF, 4);
    chk("err_half_rt", {28'd0, last_rt, last_d}, {28'd0, 4'hC, 32'd0});
    do_req(STORE_RQ, SIZE_WORD, 32'h42, 32'hFFFFFFFF, 4);
    chk("err_word_rt", {28'd0, last_rt, last_d}, {28'd0, 4'hC, 32'd0});
    do_req(STORE_RQ, 3'b011, 32'h80, 32'hFFFFFFFF, 4);
    chk("err_size_rt", {28'd0, last_rt, last_d}, {28'd0, 4'hC, 32'd0});
    do_req(6'b000101, SIZE_WORD, 32'h80, 32'hFFFFFFFF, 4);
    chk("err_rqtype_rt", {28'd0, last_rt, last_d}, {28'd0, 4'hC, 32'd0});
    do_req(LOAD_RQ, SIZE_WORD, 32'h80, 32'h0, 4);
    chk("err_no_write_80", 64'(last_d), 64'h00AA1234);
    do_req(LOAD_RQ, SIZE_WORD, 32'h40, 32'h0, 4);
    chk("err_no_write_40", 64'(last_d), 64'hDEADBEEF);

    // address wrap
    do_req(STORE_RQ, SIZE_WORD, 32'h1000, 32'h5A5AA5A5, 4);
    do_req(LOAD_RQ, SIZE_WORD, 32'h0000, 32'h0, 4);
    chk("wrap_load", 64'(last_d), 64'h5A5AA5A5);

    // reset in WAIT: write already done, response dropped
    do_req(STORE_RQ, SIZE_WORD, 32'h100, 32'h11223344, 1);
    rst = 1'b1;
    drop_future();
    #1;
    chk("midreset_outputs_a", {26'd0, ifa.l15_core_header_ack, ifa.l15_core_ack, ifa.l15_core_val,
        ifa.l15_core_returntype, ifa.l15_core_data_0}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    free_c[0] = cyc + 1; free_c[1] = cyc + 1;
    repeat (4) @(negedge clk);
    do_req(LOAD_RQ, SIZE_WORD, 32'h100, 32'h0, 4);
    chk("after_reset_load", {28'd0, last_rt, last_d}, {28'd0, 4'h0, 32'h11223344});

    // LATENCY=0 back-to-back with val held
    sel = 1;
    @(negedge clk);
    resp_cycs.delete();
    t0 = cyc;
    do_req(STORE_RQ, SIZE_WORD, 32'h200, 32'hCAFEF00D, 0);
    do_req(LOAD_RQ, SIZE_WORD, 32'h200, 32'h0, 3);
    chk("b2b_resp_count", 64'(resp_cycs.size()), 64'd2);
    chk("b2b_first_cycle", 64'(resp_cycs[0] - t0), 64'd2);
    chk("b2b_second_cycle", 64'(resp_cycs[1] - t0), 64'd5);
    chk("b2b_load_data", 64'(last_d), 64'hCAFEF00D);

    // randomized traffic on both instances
    sel = 0;
    @(negedge clk);
    random_phase(120);
    sel = 1;
    @(negedge clk);
    random_phase(120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l15_responder.md
# l15_responder

Memory-side responder for the simplified OpenPiton L1.5 request/response interface that the execute stage's memory path drives. It accepts one `core_l15_*` request at a time and acknowledges the header. After a programmable latency it returns a `l15_core_*` response, servicing loads and stores from a small internal byte-addressable memory. Its first use is the standalone bench and FPGA bring-up model for the core's load/store path; it replaces the real L1.5 in those builds.

## Interface
Parameters:
- `DEPTH`, 1024: memory size in 32-bit words; power of two.
- `LATENCY`, 2: extra wait cycles between header ack and response; 0..255.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `core_l15_val` in 1: request valid; held by the requester until `l15_core_header_ack`.
- `core_l15_rqtype` in 6: `LOAD_RQ`=6'b000000, `STORE_RQ`=6'b000001.
- `core_l15_size` in 3: byte=3'b000, half=3'b001, word=3'b010.
- `core_l15_address` in 32: byte address.
- `core_l15_data` in 32: store data, right-justified; byte in [7:0], half in [15:0].
- `l15_core_header_ack` out 1: one-cycle request accept pulse.
- `l15_core_ack` out 1: mirrors `l15_core_header_ack`.
- `l15_core_val` out 1: one-cycle response valid pulse.
- `l15_core_returntype` out 4: `LOAD_RET`=4'b0000, `ST_ACK`=4'b0100, `ERR_RET`=4'b1100.
- `l15_core_data_0` out 32: aligned load word; 0 for `ST_ACK` and `ERR_RET`.
- `l15_core_data_1` out 32: always 0.

## Operation
- FSM states: IDLE, ACK, WAIT, RESP.
- **IDLE:** when `core_l15_val`=1, latch rqtype, size, address and data, then go to ACK. `core_l15_val` is ignored in every other state.
- **ACK:** assert `header_ack` and `ack` for one cycle and load the counter with `LATENCY`.
  - Store, legal: perform the memory write in this cycle.
  - `LATENCY`=0: go to RESP. Otherwise go to WAIT.
- **WAIT:** decrement the counter each cycle. When the counter reaches 1, go to RESP.
- **RESP:** assert `l15_core_val` for one cycle with returntype and data, then go to IDLE. There is no backpressure.
- **Word index:** `address[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
- **Byte enables:**
  - byte: the lane is `address[1:0]`.
  - half: lanes {1:0} or {3:2}, chosen by `address[1]`.
  - word: all lanes.
  - Store data is replicated onto the selected lanes.
- **Error condition:** any of the following produces `ERR_RET` with no memory write and data 0:
  - half with `address[0]`=1;
  - word with `address[1:0]`≠0;
  - size not in {000, 001, 010};
  - rqtype not in {LOAD_RQ, STORE_RQ}.
- **Load data:** the full aligned word read in ACK. The core performs lane extraction and sign extension.
- **Memory reset:** memory contents are not reset and survive `rst`. Contents read before any write are X.

## Timing
- **Request to response:** request sampled in cycle 0, header_ack in cycle 1, response in cycle 2+`LATENCY`.
- **Back-to-back requests:** the next request can be sampled in cycle 3+`LATENCY`. If `core_l15_val` is still high in the RESP cycle, it is not sampled until the following IDLE cycle.
- **Store visibility:** a load issued after a store's `ST_ACK` returns the stored data.
- **Reset values:** with `rst` asserted, all outputs are 0, the state is IDLE and the counter is 0.
- **Reset mid-operation:** reset in any state drops the transaction with no response.
  - A store already in ACK has completed its write.
  - A store reset before reaching ACK never writes.

## Structure
- Package `l15_pkg` holds:
  - the rqtype, returntype and size constants;
  - the `l15_resp_state_t` enum.
- Sub-module `l15_resp_mem`: a single-port synchronous RAM of DEPTH x 32 bits with a 4-bit byte-enable write and a registered read.
  - The read is issued in ACK and consumed by RESP/WAIT.
  - With `LATENCY`=0 the read data is valid in RESP.

## Test plan
- **Reset:** `rst` pulse mid-WAIT -> all outputs 0, no `l15_core_val`, and the next request is serviced normally.
- **Word store then load, `LATENCY`=2:**
  - Store word 0xDEADBEEF at 0x40 -> header_ack in cycle 1, then `ST_ACK` in cycle 4.
  - Load word at 0x40 -> `LOAD_RET` with data 0xDEADBEEF.
- **Sub-word stores:** from word 0x00000000 at 0x80:
  - store byte 0xAA at 0x82 -> reading 0x80 returns 0x00AA0000;
  - then store half 0x1234 at 0x80 -> reading returns 0x00AA1234.
- **Errors:** each of the following returns `ERR_RET` with data 0 and leaves memory unchanged:
  - half at 0x81;
  - word at 0x42;
  - size 3'b011;
  - rqtype 6'b000101.
- **`LATENCY`=0 back-to-back:** two requests with `val` held continuously -> responses in cycles 2 and 5, with no duplicate sample of the first request.
- **Wrap, `DEPTH`=1024:** store at 0x1000 -> a load from 0x0000 returns the same data.
